// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: two one-entry slots (ALU, load) share the single write port.
// Optional RF_WB_SCOREBOARD_EN adds a pending-register scoreboard with two hazard query ports.
module rf_wb_arbiter #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              alu_valid,
   output logic              alu_ready,
   input  logic [ADDR_W-1:0] alu_addr,
   input  logic [DATA_W-1:0] alu_data,
   input  logic              ld_valid,
   output logic              ld_ready,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_data,
   output logic              rf_we,
   output logic [ADDR_W-1:0] rf_addr,
   output logic [DATA_W-1:0] rf_data,
   output logic              busy
`ifdef RF_WB_SCOREBOARD_EN
   ,
   input  logic [ADDR_W-1:0]    qa_addr,
   input  logic [ADDR_W-1:0]    qb_addr,
   output logic                 qa_hazard,
   output logic                 qb_hazard,
   output logic [2**ADDR_W-1:0] pending
`endif
);

   logic              alu_sv;
   logic [ADDR_W-1:0] alu_sa;
   logic [DATA_W-1:0] alu_sd;
   logic              ld_sv;
   logic [ADDR_W-1:0] ld_sa;
   logic [DATA_W-1:0] ld_sd;

   // ld_older: load slot was captured strictly before the ALU slot
   logic              ld_older;
   // rr_ld: round-robin pointer names the load requester
   logic              rr_ld;
   logic [ADDR_W-1:0] last_addr;
   logic [DATA_W-1:0] last_data;

   logic grant_alu;
   logic grant_ld;
   logic alu_acc;
   logic ld_acc;
   logic alu_load;
   logic ld_load;
   logic alu_keep;
   logic ld_keep;

   always_comb begin
      grant_alu = 1'b0;
      grant_ld  = 1'b0;
      if (alu_sv && ld_sv) begin
         if (alu_sa == ld_sa) begin
            if (ld_older) grant_ld  = 1'b1;
            else          grant_alu = 1'b1;
         end else if (rr_ld) begin
            grant_ld = 1'b1;
         end else begin
            grant_alu = 1'b1;
         end
      end else if (alu_sv) begin
         grant_alu = 1'b1;
      end else if (ld_sv) begin
         grant_ld = 1'b1;
      end
   end

   assign alu_ready = !alu_sv || grant_alu;
   assign ld_ready  = !ld_sv || grant_ld;

   assign alu_acc  = alu_valid && alu_ready;
   assign ld_acc   = ld_valid && ld_ready;
   // Writes to register 0 complete the handshake but never occupy a slot
   assign alu_load = alu_acc && (alu_addr != '0);
   assign ld_load  = ld_acc && (ld_addr != '0);
   assign alu_keep = alu_sv && !grant_alu;
   assign ld_keep  = ld_sv && !grant_ld;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         alu_sv    <= 1'b0;
         alu_sa    <= '0;
         alu_sd    <= '0;
         ld_sv     <= 1'b0;
         ld_sa     <= '0;
         ld_sd     <= '0;
         ld_older  <= 1'b0;
         rr_ld     <= 1'b0;
         last_addr <= '0;
         last_data <= '0;
      end else begin
         alu_sv <= alu_load || alu_keep;
         ld_sv  <= ld_load || ld_keep;
         if (alu_load) begin
            alu_sa <= alu_addr;
            alu_sd <= alu_data;
         end
         if (ld_load) begin
            ld_sa <= ld_addr;
            ld_sd <= ld_data;
         end
         // Same-edge capture counts the ALU as older, so the load value lands last
         if (alu_load || ld_load)
            ld_older <= alu_load && !ld_load && ld_keep;
         if (alu_sv && ld_sv)
            rr_ld <= grant_alu;
         if (grant_alu) begin
            last_addr <= alu_sa;
            last_data <= alu_sd;
         end else if (grant_ld) begin
            last_addr <= ld_sa;
            last_data <= ld_sd;
         end
      end
   end

   always_comb begin
      rf_we   = grant_alu || grant_ld;
      rf_addr = last_addr;
      rf_data = last_data;
      if (grant_alu) begin
         rf_addr = alu_sa;
         rf_data = alu_sd;
      end else if (grant_ld) begin
         rf_addr = ld_sa;
         rf_data = ld_sd;
      end
   end

   assign busy = alu_sv || ld_sv;

`ifdef RF_WB_SCOREBOARD_EN
   always_comb begin
      pending = '0;
      if (alu_sv) pending[alu_sa] = 1'b1;
      if (ld_sv)  pending[ld_sa]  = 1'b1;
      pending[0] = 1'b0;
   end

   // Hazard also covers a request being offered this cycle, before it reaches a slot
   always_comb begin
      qa_hazard = pending[qa_addr]
                  || (alu_valid && (alu_addr == qa_addr) && (qa_addr != '0))
                  || (ld_valid && (ld_addr == qa_addr) && (qa_addr != '0));
      qb_hazard = pending[qb_addr]
                  || (alu_valid && (alu_addr == qb_addr) && (qb_addr != '0))
                  || (ld_valid && (ld_addr == qb_addr) && (qb_addr != '0));
   end
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed vector table plus reset and scoreboard sequences.
module tb_rf_wb_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        alu_valid;
   logic        alu_ready;
   logic [4:0]  alu_addr;
   logic [31:0] alu_data;
   logic        ld_valid;
   logic        ld_ready;
   logic [4:0]  ld_addr;
   logic [31:0] ld_data;
   logic        rf_we;
   logic [4:0]  rf_addr;
   logic [31:0] rf_data;
   logic        busy;
`ifdef RF_WB_SCOREBOARD_EN
   logic [4:0]  qa_addr;
   logic [4:0]  qb_addr;
   logic        qa_hazard;
   logic        qb_hazard;
   logic [31:0] pending;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   int n_writes = 0;
   logic [31:0] rf_model [32] = '{default: '0};

   always #5 clk = ~clk;

   rf_wb_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
      .clk       (clk),
      .rst       (rst),
      .alu_valid (alu_valid),
      .alu_ready (alu_ready),
      .alu_addr  (alu_addr),
      .alu_data  (alu_data),
      .ld_valid  (ld_valid),
      .ld_ready  (ld_ready),
      .ld_addr   (ld_addr),
      .ld_data   (ld_data),
      .rf_we     (rf_we),
      .rf_addr   (rf_addr),
      .rf_data   (rf_data),
      .busy      (busy)
`ifdef RF_WB_SCOREBOARD_EN
      ,
      .qa_addr   (qa_addr),
      .qb_addr   (qb_addr),
      .qa_hazard (qa_hazard),
      .qb_hazard (qb_hazard),
      .pending   (pending)
`endif
   );

   always @(posedge clk) begin
      if (!rst && rf_we) begin
         rf_model[rf_addr] <= rf_data;
         n_writes <= n_writes + 1;
      end
   end

   typedef struct {
      logic        av;
      logic [4:0]  aa;
      logic [31:0] ad;
      logic        lv;
      logic [4:0]  la;
      logic [31:0] ld;
      logic        we;
      logic [4:0]  ra;
      logic [31:0] rd;
      logic        ar;
      logic        lr;
      logic        bz;
   } vec_t;

   vec_t vecs [24];

   function automatic vec_t mk(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                               input logic lv, input logic [4:0] la, input logic [31:0] ld,
                               input logic we, input logic [4:0] ra, input logic [31:0] rd,
                               input logic ar, input logic lr, input logic bz);
      vec_t v;
      v.av = av; v.aa = aa; v.ad = ad;
      v.lv = lv; v.la = la; v.ld = ld;
      v.we = we; v.ra = ra; v.rd = rd;
      v.ar = ar; v.lr = lr; v.bz = bz;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic idle_inputs();
      alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
      ld_valid  = 1'b0; ld_addr  = '0; ld_data  = '0;
   endtask

   initial begin
      //            av aa     ad          lv la     ld          we ra     rd          ar lr bz
      vecs[0]  = mk(1, 5'd5,  32'h11,     0, 5'd0,  32'h0,      0, 5'd0,  32'h0,      1, 1, 0);
      vecs[1]  = mk(1, 5'd6,  32'h22,     0, 5'd0,  32'h0,      1, 5'd5,  32'h11,     1, 1, 1);
      vecs[2]  = mk(1, 5'd7,  32'h33,     0, 5'd0,  32'h0,      1, 5'd6,  32'h22,     1, 1, 1);
      vecs[3]  = mk(0, 5'd0,  32'h0,      0, 5'd0,  32'h0,      1, 5'd7,  32'h33,     1, 1, 1);
      vecs[4]  = mk(0, 5'd0,  32'h0,      0, 5'd0,  32'h0,      0, 5'd7,  32'h33,     1, 1, 0);
      vecs[5]  = mk(1, 5'd8,  32'hA,      1, 5'd9,  32'hB,      0, 5'd7,  32'h33,     1, 1, 0);
      vecs[6]  = mk(1, 5'd8,  32'hC,      1, 5'd9,  32'hD,      1, 5'd8,  32'hA,      1, 0, 1);
      vecs[7]  = mk(1, 5'd8,  32'hE,      1, 5'd9,  32'hD,      1, 5'd9,  32'hB,      0, 1, 1);
      vecs[8]  = mk(1, 5'd8,  32'hE,      0, 5'd0,  32'h0,      1, 5'd8,  32'hC,      1, 0, 1);
      vecs[9]  = mk(0, 5'd0,  32'h0,      0, 5'd0,  32'h0,      1, 5'd9,  32'hD,      0, 1, 1);
      vecs[10] = mk(0, 5'd0,  32'h0,      0, 5'd0,  32'h0,      1, 5'd8,  32'hE,      1, 1, 1);
      vecs[11] = mk(0, 5'd0,  32'h0,      0, 5'd0,  32'h0,      0, 5'd8,  32'hE,      1, 1, 0);
      // load r10 waits behind ALU r11, then ALU r10 arrives: load must land first
      vecs[12] = mk(1, 5'd11, 32'h5,      1, 5'd10, 32'h3,      0, 5'd8,  32'hE,      1, 1, 0);
      vecs[13] = mk(1, 5'd10, 32'h4,      0, 5'd0,  32'h0,      1, 5'd11, 32'h5,      1, 0, 1);
      vecs[14] = mk(0, 5'd0,  32'h0,      0, 5'd0,  32'h0,      1, 5'd10, 32'h3,      0, 1, 1);
      vecs[15] = mk(0, 5'd0,  32'h0,      0, 5'd0,  32'h0,      1, 5'd10, 32'h4,      1, 1, 1);
      // contended ALU grant leaves the pointer on LD before the same-cycle test
      vecs[16] = mk(1, 5'd13, 32'h7,      1, 5'd14, 32'h8,      0, 5'd10, 32'h4,      1, 1, 0);
      vecs[17] = mk(0, 5'd0,  32'h0,      0, 5'd0,  32'h0,      1, 5'd13, 32'h7,      1, 0, 1);
      vecs[18] = mk(0, 5'd0,  32'h0,      0, 5'd0,  32'h0,      1, 5'd14, 32'h8,      1, 1, 1);
      vecs[19] = mk(1, 5'd10, 32'h1,      1, 5'd10, 32'h2,      0, 5'd14, 32'h8,      1, 1, 0);
      vecs[20] = mk(0, 5'd0,  32'h0,      0, 5'd0,  32'h0,      1, 5'd10, 32'h1,      1, 0, 1);
      vecs[21] = mk(0, 5'd0,  32'h0,      0, 5'd0,  32'h0,      1, 5'd10, 32'h2,      1, 1, 1);
      vecs[22] = mk(0, 5'd0,  32'h0,      1, 5'd0,  32'hFFFF,   0, 5'd10, 32'h2,      1, 1, 0);
      vecs[23] = mk(0, 5'd0,  32'h0,      0, 5'd0,  32'h0,      0, 5'd10, 32'h2,      1, 1, 0);

      idle_inputs();
`ifdef RF_WB_SCOREBOARD_EN
      qa_addr = '0;
      qb_addr = '0;
`endif
      rst = 1'b1;
      #3;
      chk("reset rf_we",   {31'b0, rf_we}, 32'h0);
      chk("reset busy",    {31'b0, busy},  32'h0);
      chk("reset rf_addr", {27'b0, rf_addr}, 32'h0);
      chk("reset rf_data", rf_data, 32'h0);
      #10;
      rst = 1'b0;
      @(negedge clk);
      chk("post-reset alu_ready", {31'b0, alu_ready}, 32'h1);
      chk("post-reset ld_ready",  {31'b0, ld_ready},  32'h1);

      for (int i = 0; i < 24; i++) begin
         @(posedge clk);
         #1;
         alu_valid = vecs[i].av; alu_addr = vecs[i].aa; alu_data = vecs[i].ad;
         ld_valid  = vecs[i].lv; ld_addr  = vecs[i].la; ld_data  = vecs[i].ld;
         @(negedge clk);
         chk($sformatf("v%0d rf_we", i),     {31'b0, rf_we},     {31'b0, vecs[i].we});
         chk($sformatf("v%0d rf_addr", i),   {27'b0, rf_addr},   {27'b0, vecs[i].ra});
         chk($sformatf("v%0d rf_data", i),   rf_data,            vecs[i].rd);
         chk($sformatf("v%0d alu_ready", i), {31'b0, alu_ready}, {31'b0, vecs[i].ar});
         chk($sformatf("v%0d ld_ready", i),  {31'b0, ld_ready},  {31'b0, vecs[i].lr});
         chk($sformatf("v%0d busy", i),      {31'b0, busy},      {31'b0, vecs[i].bz});
      end
      @(posedge clk);
      #1;
      idle_inputs();
      chk("rf r5",  rf_model[5],  32'h11);
      chk("rf r6",  rf_model[6],  32'h22);
      chk("rf r7",  rf_model[7],  32'h33);
      chk("rf r8",  rf_model[8],  32'hE);
      chk("rf r9",  rf_model[9],  32'hD);
      chk("rf r10", rf_model[10], 32'h2);
      chk("rf r0",  rf_model[0],  32'h0);
      chk("write count", n_writes, 32'd15);

      // Mid-cycle reset with both slots full
      @(posedge clk);
      #1;
      alu_valid = 1'b1; alu_addr = 5'd20; alu_data = 32'h55;
      ld_valid  = 1'b1; ld_addr  = 5'd21; ld_data  = 32'h66;
      @(posedge clk);
      #1;
      idle_inputs();
      chk("full rf_we", {31'b0, rf_we}, 32'h1);
      chk("full busy",  {31'b0, busy},  32'h1);
      #2;
      rst = 1'b1;
      #1;
      chk("async reset rf_we", {31'b0, rf_we}, 32'h0);
      chk("async reset busy",  {31'b0, busy},  32'h0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("release alu_ready", {31'b0, alu_ready}, 32'h1);
      chk("release ld_ready",  {31'b0, ld_ready},  32'h1);
      chk("release rf_we",     {31'b0, rf_we},     32'h0);
      chk("release busy",      {31'b0, busy},      32'h0);
      chk("release rf_addr",   {27'b0, rf_addr},   32'h0);
      chk("release rf_data",   rf_data,            32'h0);
      chk("dropped r20", rf_model[20], 32'h0);
      chk("dropped r21", rf_model[21], 32'h0);

`ifdef RF_WB_SCOREBOARD_EN
      @(posedge clk);
      #1;
      qa_addr = 5'd12;
      qb_addr = 5'd0;
      alu_valid = 1'b1; alu_addr = 5'd12; alu_data = 32'h12;
      @(negedge clk);
      chk("sb offered qa_hazard", {31'b0, qa_hazard}, 32'h1);
      chk("sb offered qb_hazard", {31'b0, qb_hazard}, 32'h0);
      chk("sb offered pending",   pending, 32'h0);
      @(posedge clk);
      #1;
      idle_inputs();
      @(negedge clk);
      chk("sb held qa_hazard", {31'b0, qa_hazard}, 32'h1);
      chk("sb held pending",   pending, 32'h0000_1000);
      chk("sb held qb_hazard", {31'b0, qb_hazard}, 32'h0);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("sb after qa_hazard", {31'b0, qa_hazard}, 32'h0);
      chk("sb after pending",   pending, 32'h0);
      chk("sb after rf r12",    rf_model[12], 32'h12);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
